// File: rtl/wash_panel_input_if.sv
// wash_panel_input_if: panel pin levels, controller status and the
// conditioned requests exchanged between the panel front end and its user.
interface wash_panel_input_if;
   logic [1:0] clk_freq;
   logic       coin_btn_raw;
   logic       dbl_btn_raw;
   logic       pause_sw_raw;
   logic [2:0] cur_state;
   logic       wash_done;
   logic       coin_in;
   logic       double_wash;
   logic       timer_pause;
   logic [2:0] credit;

   modport master (
      output clk_freq, coin_btn_raw, dbl_btn_raw, pause_sw_raw,
      output cur_state, wash_done,
      input  coin_in, double_wash, timer_pause, credit
   );

   modport slave (
      input  clk_freq, coin_btn_raw, dbl_btn_raw, pause_sw_raw,
      input  cur_state, wash_done,
      output coin_in, double_wash, timer_pause, credit
   );
endinterface

// File: rtl/wash_panel_input.sv
// wash_panel_input: syncs and debounces coin/double-wash/pause contacts.
// Optional COIN_CREDIT_EN: collect COINS_PER_WASH coins before start pulse.
module wash_panel_input #(
   parameter int DEB_W  = 17,
   parameter int DEB_F1 = 10000,
   parameter int DEB_F2 = 20000,
   parameter int DEB_F3 = 40000,
   parameter int DEB_F4 = 80000
`ifdef COIN_CREDIT_EN
   ,
   parameter int COINS_PER_WASH = 2
`endif
) (
   input logic             clk,
   input logic             rst,
   wash_panel_input_if.slave bus
);

   // bit 0 coin, bit 1 double-wash, bit 2 pause
   logic [2:0]       raw;
   logic [2:0]       s1;
   logic [2:0]       s2;
   logic [2:0]       stable;
   logic [2:0]       stable_d;
   logic [2:0]       rise_q;
   logic [DEB_W-1:0] cnt     [3];
   logic [DEB_W:0]   cnt_inc [3];
   logic [DEB_W:0]   thr;
   logic             wd_d;
   logic             idle;
   logic             wd_rise;
   logic             accept;

   assign raw     = {bus.pause_sw_raw, bus.dbl_btn_raw, bus.coin_btn_raw};
   assign idle    = (bus.cur_state == 3'd0);
   assign wd_rise = bus.wash_done & ~wd_d;
   assign accept  = rise_q[0] & idle & ~bus.wash_done;

   // debounce threshold follows clk_freq every cycle
   always_comb begin
      unique case (bus.clk_freq)
         2'b00: thr = (DEB_W+1)'(DEB_F1);
         2'b01: thr = (DEB_W+1)'(DEB_F2);
         2'b10: thr = (DEB_W+1)'(DEB_F3);
         2'b11: thr = (DEB_W+1)'(DEB_F4);
      endcase
   end

   // widened increment so the threshold compare cannot overflow
   always_comb begin
      for (int i = 0; i < 3; i++)
         cnt_inc[i] = {1'b0, cnt[i]} + (DEB_W+1)'(1);
   end

   // two-flop sync, per-input debounce counter, stable history and rise
   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= '0;
         s2       <= '0;
         stable   <= '0;
         stable_d <= '0;
         rise_q   <= '0;
         wd_d     <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         s1       <= raw;
         s2       <= s1;
         stable_d <= stable;
         rise_q   <= stable & ~stable_d;
         wd_d     <= bus.wash_done;
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt_inc[i] >= thr) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else if (~&cnt[i]) begin
               cnt[i] <= cnt_inc[i][DEB_W-1:0];
            end
         end
      end
   end

`ifdef COIN_CREDIT_EN
   localparam logic [2:0] CPW = 3'(COINS_PER_WASH);

   // registered requests; coins accumulate until a full wash is paid
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.coin_in     <= 1'b0;
         bus.double_wash <= 1'b0;
         bus.timer_pause <= 1'b0;
         bus.credit      <= '0;
      end else begin
         bus.timer_pause <= stable[2] & ~idle;
         if (wd_rise)
            bus.double_wash <= 1'b0;
         else if (rise_q[1] & idle)
            bus.double_wash <= ~bus.double_wash;
         bus.coin_in <= 1'b0;
         if (!idle || wd_rise) begin
            bus.credit <= '0;
         end else if (accept) begin
            if (bus.credit + 3'd1 == CPW) begin
               bus.coin_in <= 1'b1;
               bus.credit  <= '0;
            end else if (bus.credit != 3'd7) begin
               bus.credit <= bus.credit + 3'd1;
            end
         end
      end
   end
`else
   assign bus.credit = '0;

   // registered requests; each accepted coin starts a wash directly
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.coin_in     <= 1'b0;
         bus.double_wash <= 1'b0;
         bus.timer_pause <= 1'b0;
      end else begin
         bus.timer_pause <= stable[2] & ~idle;
         if (wd_rise)
            bus.double_wash <= 1'b0;
         else if (rise_q[1] & idle)
            bus.double_wash <= ~bus.double_wash;
         bus.coin_in <= accept;
      end
   end
`endif

endmodule
